// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data ports share one synchronous RAM port.
// Partial-byte data writes are done as a read followed by a merged write (read-modify-write).
module mem_arb #(
    parameter int STARVE_LIM = 4,
    parameter int WORD       = 32,
    parameter int ADDR       = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    output logic            i_ack,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_ack,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,

    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q,
    input  logic [ADDR-1:0] mem_ao,

    output logic            err,
    output logic            state_o
);

    // Handshake: a request is held high by the requester until its ack; the ack
    // is combinational and marks the single cycle in which the access issues.

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            pend_i_q, pend_d_q;
    logic [ADDR-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic [3:0]      be_q;
    logic [WORD-1:0] i_rdata_q, i_rdata_d;
    logic [WORD-1:0] d_rdata_q, d_rdata_d;
    logic            err_q, err_d;

    logic            i_win;
    logic            grant_i_rd, grant_d_rd, grant_merge;
    logic            check_en;
    logic [WORD-1:0] merged;

    assign state_o = state_q;
    assign err     = err_q;

    // Instruction port only beats a competing data request once it has starved.
    assign i_win = i_req && (!d_req || (starve_q == LIM));

    always_comb begin
        merged = mem_q;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        mem_a       = '0;
        mem_w       = 1'b0;
        mem_d       = '0;
        grant_i_rd  = 1'b0;
        grant_d_rd  = 1'b0;
        grant_merge = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (i_win) begin
                        i_ack      = 1'b1;
                        mem_a      = i_addr;
                        grant_i_rd = 1'b1;
                    end else if (d_req) begin
                        d_ack = 1'b1;
                        if (!d_we) begin
                            mem_a      = d_addr;
                            grant_d_rd = 1'b1;
                        end else if (d_be == 4'b1111) begin
                            mem_a = d_addr;
                            mem_w = 1'b1;
                            mem_d = d_wdata;
                        end else if (d_be != 4'b0000) begin
                            mem_a       = d_addr;
                            grant_merge = 1'b1;
                            state_d     = MERGE;
                        end
                    end
                end
                MERGE: begin
                    mem_a   = addr_q;
                    mem_w   = 1'b1;
                    mem_d   = merged;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read returns land one cycle after issue; a reset in that cycle suppresses them.
    assign i_rvalid = pend_i_q && !rst;
    assign d_rvalid = pend_d_q && !rst;
    assign i_rdata_d = i_rvalid ? mem_q : i_rdata_q;
    assign d_rdata_d = d_rvalid ? mem_q : d_rdata_q;
    assign i_rdata   = i_rdata_d;
    assign d_rdata   = d_rdata_d;

    assign check_en = pend_i_q || pend_d_q || (state_q == MERGE);
    assign err_d    = err_q || (check_en && (mem_ao != addr_q));

    always_comb begin
        starve_d = starve_q;
        if (i_ack) begin
            starve_d = '0;
        end else if (i_req && (starve_q != LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            pend_i_q  <= 1'b0;
            pend_d_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            pend_i_q  <= grant_i_rd;
            pend_d_q  <= grant_d_rd;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            if (grant_i_rd || grant_d_rd || grant_merge) begin
                addr_q <= mem_a;
            end
            if (grant_merge) begin
                wdata_q <= d_wdata;
                be_q    <= d_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural one-cycle-latency RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [15:0] mem_a;
    logic        mem_w;
    logic [31:0] mem_d;
    logic [31:0] mem_q = 32'h0;
    logic [15:0] mem_ao = 16'h0;
    logic        err;
    logic        state_o;

    logic [31:0] mem [0:65535];
    logic        force_echo = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_arb #(.STARVE_LIM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_a    (mem_a),
        .mem_w    (mem_w),
        .mem_d    (mem_d),
        .mem_q    (mem_q),
        .mem_ao   (mem_ao),
        .err      (err),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: writes do not touch mem_q; mem_ao echoes the sampled address.
    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_a] <= mem_d;
        end else begin
            mem_q <= mem[mem_a];
        end
        mem_ao <= force_echo ? 16'h0001 : mem_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        i_req   = 1'b0;
        i_addr  = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'b0;
        d_addr  = 16'h0;
        d_wdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1'b1;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0020] = 32'h11223344;
        mem[16'h0030] = 32'h55667788;
        mem[16'h0040] = 32'h0;
        for (int a = 0; a < 4; a++) mem[a] = 32'hA0A00000 + a;

        // Reset: requests are ignored and nothing is written.
        step();
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 16'h0040; d_wdata = 32'h12345678;
        smp();
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_w", mem_w, 0);
        step(); clr(); rst = 1'b0;
        smp();
        chk("por_i_rvalid", i_rvalid, 0);
        chk("por_d_rvalid", d_rvalid, 0);
        chk("por_i_rdata", i_rdata, 0);
        chk("por_d_rdata", d_rdata, 0);
        chk("por_err", err, 0);
        chk("por_state", state_o, 0);
        chk("por_mem_a", mem_a, 0);
        chk("por_mem_d", mem_d, 0);
        chk("por_mem40", mem[16'h0040], 32'h0);

        // Single instruction read.
        step(); i_req = 1'b1; i_addr = 16'h0010;
        smp();
        chk("rd_i_ack", i_ack, 1);
        chk("rd_d_ack", d_ack, 0);
        chk("rd_mem_a", mem_a, 32'h10);
        chk("rd_mem_w", mem_w, 0);
        chk("rd_rvalid_c0", i_rvalid, 0);
        step(); clr();
        smp();
        chk("rd_rvalid_c1", i_rvalid, 1);
        chk("rd_rdata_c1", i_rdata, 32'hDEADBEEF);
        chk("rd_d_rvalid_c1", d_rvalid, 0);
        step();
        smp();
        chk("rd_rvalid_c2", i_rvalid, 0);
        chk("rd_rdata_hold", i_rdata, 32'hDEADBEEF);

        // Partial byte write (read-modify-write).
        step(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 16'h0020; d_wdata = 32'h0000AA00;
        smp();
        chk("bw_d_ack", d_ack, 1);
        chk("bw_grant_mem_w", mem_w, 0);
        chk("bw_grant_mem_a", mem_a, 32'h20);
        step(); clr(); i_req = 1'b1; i_addr = 16'h0010;
        smp();
        chk("bw_state_merge", state_o, 1);
        chk("bw_merge_mem_w", mem_w, 1);
        chk("bw_merge_mem_a", mem_a, 32'h20);
        chk("bw_merge_mem_d", mem_d, 32'h1122AA44);
        chk("bw_merge_i_ack", i_ack, 0);
        chk("bw_merge_d_rvalid", d_rvalid, 0);
        step();
        smp();
        chk("bw_back_idle", state_o, 0);
        chk("bw_i_ack_after", i_ack, 1);
        chk("bw_d_rvalid_after", d_rvalid, 0);
        chk("bw_mem20", mem[16'h0020], 32'h1122AA44);
        step(); clr(); d_req = 1'b1; d_addr = 16'h0020;
        smp();
        chk("bw_rb_d_ack", d_ack, 1);
        step(); clr();
        smp();
        chk("bw_rb_d_rvalid", d_rvalid, 1);
        chk("bw_rb_d_rdata", d_rdata, 32'h1122AA44);

        // Full write, then a zero-enable write that must not touch memory.
        step(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 16'h0040; d_wdata = 32'hCAFEF00D;
        smp();
        chk("fw_d_ack", d_ack, 1);
        chk("fw_mem_w", mem_w, 1);
        chk("fw_mem_d", mem_d, 32'hCAFEF00D);
        step(); d_wdata = 32'h0; d_be = 4'b0000;
        smp();
        chk("fw_no_rvalid", d_rvalid, 0);
        chk("fw_state_idle", state_o, 0);
        chk("zw_d_ack", d_ack, 1);
        chk("zw_mem_w", mem_w, 0);
        step(); clr();
        smp();
        chk("zw_mem40", mem[16'h0040], 32'hCAFEF00D);

        // Contention with continuous data reads: instruction wins in cycle 4.
        for (int c = 0; c < 6; c++) begin
            step();
            i_req = 1'b1; i_addr = 16'h0010;
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000;
            smp();
            chk($sformatf("ct_i_ack_c%0d", c), i_ack, (c == 4) ? 1 : 0);
            chk($sformatf("ct_d_ack_c%0d", c), d_ack, (c != 4) ? 1 : 0);
            if (c == 5) begin
                chk("ct_i_rvalid_c5", i_rvalid, 1);
                chk("ct_i_rdata_c5", i_rdata, 32'hDEADBEEF);
            end
        end
        step(); clr();
        step();

        // Pipelined data reads of 0x0..0x3.
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 4) begin
                d_req = 1'b1; d_addr = 16'(c);
            end else begin
                d_req = 1'b0;
            end
            smp();
            chk($sformatf("pl_d_ack_c%0d", c), d_ack, (c < 4) ? 1 : 0);
            chk($sformatf("pl_d_rvalid_c%0d", c), d_rvalid, (c >= 1 && c <= 4) ? 1 : 0);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("pl_d_rdata_c%0d", c), d_rdata, 32'hA0A00000 + 32'(c - 1));
            end
        end
        step(); clr();

        // Reset during the merge cycle abandons the write.
        step(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 16'h0030; d_wdata = 32'h000000FF;
        smp();
        chk("mr_d_ack", d_ack, 1);
        step(); clr(); rst = 1'b1;
        smp();
        chk("mr_state_merge", state_o, 1);
        chk("mr_mem_w", mem_w, 0);
        step(); rst = 1'b0;
        smp();
        chk("mr_state_idle", state_o, 0);
        chk("mr_mem_w_after", mem_w, 0);
        chk("mr_d_rvalid", d_rvalid, 0);
        chk("mr_d_rdata", d_rdata, 0);
        chk("mr_i_rdata", i_rdata, 0);
        chk("mr_err", err, 0);
        chk("mr_mem30", mem[16'h0030], 32'h55667788);

        // A read issued just before reset returns nothing.
        step(); i_req = 1'b1; i_addr = 16'h0010;
        smp();
        chk("pr_i_ack", i_ack, 1);
        step(); clr(); rst = 1'b1;
        smp();
        chk("pr_i_rvalid_rst", i_rvalid, 0);
        step(); rst = 1'b0;
        smp();
        chk("pr_i_rvalid_after", i_rvalid, 0);
        chk("pr_i_rdata_after", i_rdata, 0);

        // Address echo mismatch sets a sticky error.
        step(); force_echo = 1'b1; d_req = 1'b1; d_addr = 16'h0002;
        smp();
        chk("ec_d_ack", d_ack, 1);
        step(); clr(); force_echo = 1'b0;
        smp();
        chk("ec_err_n1", err, 0);
        chk("ec_d_rvalid_n1", d_rvalid, 1);
        step();
        smp();
        chk("ec_err_n2", err, 1);
        step(); step();
        smp();
        chk("ec_err_held", err, 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        smp();
        chk("ec_err_cleared", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter STARVE_LIM, default 4, which sets how many consecutive cycles an instruction request may lose to the data port.
REQ-002 Widths SHALL come from include/params.vh: WORD = 32 and ADDR = 16.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch read request, held until acked.
REQ-006 i_addr  in  ADDR  instruction-fetch word address.
REQ-007 i_ack  out  1  instruction request accepted this cycle.
REQ-008 i_rvalid, i_rdata  out  1, WORD  instruction read return.
REQ-009 d_req, d_we  in  1, 1  data request; write when d_we=1.
REQ-010 d_be  in  4  write byte enables; d_be[0] selects bits 7:0.
REQ-011 d_addr, d_wdata  in  ADDR, WORD  data address and write data.
REQ-012 d_ack  out  1  data request accepted this cycle.
REQ-013 d_rvalid, d_rdata  out  1, WORD  data read return.
REQ-014 mem_a, mem_w, mem_d  out  ADDR, 1, WORD  address, write strobe and write data to the memory.
REQ-015 mem_q, mem_ao  in  WORD, ADDR  registered read data and echoed address from the memory, one cycle after issue.
REQ-016 err  out  1  sticky flag for an address-echo mismatch.

Function
REQ-017 The memory contract SHALL be as follows: the memory samples mem_a/mem_w/mem_d at the edge ending issue cycle N; for reads, mem_q and mem_ao are valid in cycle N+1; writes do not update mem_q.
REQ-018 Acks and memory outputs SHALL be combinational from the current requests and state; at most one access SHALL issue per cycle.
REQ-019 The FSM SHALL have two states, IDLE and MERGE; grants SHALL occur only in IDLE.
REQ-020 In IDLE the data port SHALL win over the instruction port, except when the starve counter equals STARVE_LIM, in which case the instruction port wins.
REQ-021 The starve counter SHALL increment on each cycle where i_req=1 and i_ack=0, clear on i_ack, and saturate at STARVE_LIM.
REQ-022 A read grant SHALL drive mem_a=addr and mem_w=0, then set the pending tag (I or D) and latch addr.
REQ-023 In cycle N+1 after a read grant, the tagged rvalid SHALL be 1 for exactly one cycle, and rdata SHALL equal mem_q.
REQ-024 Each rdata SHALL hold its value until the next rvalid of the same port.
REQ-025 A full write (d_be=4'b1111) SHALL drive mem_w=1 and mem_d=d_wdata for one cycle with no rvalid.
REQ-026 A partial write (d_be neither 0000 nor 1111) SHALL be handled in two steps:
- Grant cycle: issue a read of d_addr, latch addr, wdata and be, go to MERGE.
- MERGE cycle: drive mem_w=1, mem_a=latched addr and mem_d=per-byte mux (be lane ? wdata lane : mem_q lane), with no rvalid and i_ack=d_ack=0, then return to IDLE.
REQ-027 A write with d_be=0000 SHALL be acked with no memory write, mem_w=0.
REQ-028 When nothing is granted, mem_a SHALL be 0, mem_w SHALL be 0 and mem_d SHALL be 0.
REQ-029 Every read return, including the MERGE read, SHALL compare mem_ao with the latched address; on mismatch err SHALL be set to 1 and held until reset.
REQ-030 A simultaneous i_req and d_req in IDLE SHALL produce exactly one ack.
REQ-031 The losing request SHALL be served no later than STARVE_LIM+2 cycles later.
REQ-032 Back-to-back reads SHALL sustain one return per cycle.

Reset
REQ-033 On a clock edge with rst=1, the block SHALL reset state to IDLE and clear pending tags, the starve counter, i_rvalid, d_rvalid, i_rdata, d_rdata and err to 0.
REQ-034 While rst=1, i_ack, d_ack and mem_w SHALL be 0, including when the state is MERGE, so a partial write is abandoned unwritten.
REQ-035 A read issued in the cycle before reset SHALL produce no rvalid.

Verification
REQ-036 Single read: mem[0x0010]=0xDEADBEEF, i_req with i_addr=0x0010 -> i_ack in cycle 0; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle 1 only.
REQ-037 Byte write: mem[0x0020]=0x11223344, d_we=1, d_be=4'b0010, d_wdata=0x0000AA00 -> MERGE writes 0x1122AA44; a later read returns 0x1122AA44; no rvalid during the write.
REQ-038 Contention: i_req and d_req held high with continuous data reads, STARVE_LIM=4 -> i_ack in cycle 4, d_ack in cycles 0-3 and 5.
REQ-039 Mid-RMW reset: rst=1 in the MERGE cycle -> mem_w=0 that cycle; memory is unchanged and all outputs are 0 the next cycle.
REQ-040 Echo check: force mem_ao=0x0001 for a read of 0x0002 -> err=1 from cycle N+2 and held until rst.
REQ-041 Pipelined reads: d reads of 0x0..0x3 on consecutive cycles -> d_rvalid high for 4 consecutive cycles with data in order.
